// File: rtl/timing_gen_vg.sv
// Programmable raster timing generator: h/v counters, sync/DE decode and a
// double-buffered config that only takes effect at a frame boundary or while idle.
module timing_gen_vg #(
  parameter int X_BITS = 13,
  parameter int Y_BITS = 13
) (
  input  logic              reset,
  input  logic              clk_in,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [X_BITS-1:0] cfg_h_total,
  input  logic [X_BITS-1:0] cfg_h_active,
  input  logic [X_BITS-1:0] cfg_h_front,
  input  logic [X_BITS-1:0] cfg_h_sync,
  input  logic [Y_BITS-1:0] cfg_v_total,
  input  logic [Y_BITS-1:0] cfg_v_active,
  input  logic [Y_BITS-1:0] cfg_v_front,
  input  logic [Y_BITS-1:0] cfg_v_sync,
  input  logic              cfg_hs_pol,
  input  logic              cfg_vs_pol,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hn_out,
  output logic              vn_out,
  output logic              dn_out,
  output logic [X_BITS-1:0] total_active_pix,
  output logic [Y_BITS-1:0] total_active_lines,
  output logic              frame_start,
  output logic [7:0]        frame_count,
  output logic              cfg_pending,
  output logic              cfg_err
);

  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;

  typedef struct packed {
    logic [X_BITS-1:0] h_total;
    logic [X_BITS-1:0] h_active;
    logic [X_BITS-1:0] h_front;
    logic [X_BITS-1:0] h_sync;
    logic [Y_BITS-1:0] v_total;
    logic [Y_BITS-1:0] v_active;
    logic [Y_BITS-1:0] v_front;
    logic [Y_BITS-1:0] v_sync;
    logic              hs_pol;
    logic              vs_pol;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    h_total:  X_BITS'(1650), h_active: X_BITS'(1280),
    h_front:  X_BITS'(110),  h_sync:   X_BITS'(40),
    v_total:  Y_BITS'(750),  v_active: Y_BITS'(720),
    v_front:  Y_BITS'(5),    v_sync:   Y_BITS'(5),
    hs_pol:   1'b1,          vs_pol:   1'b1
  };

  cfg_t              cfg_in;
  cfg_t              act;
  cfg_t              pend;
  logic [X_BITS-1:0] h_cnt;
  logic [Y_BITS-1:0] v_cnt;

  logic [XW-1:0] in_h_sum;
  logic [YW-1:0] in_v_sum;
  logic          cfg_valid;
  logic [XW-1:0] h_sync_start;
  logic [XW-1:0] h_sync_end;
  logic [YW-1:0] v_sync_start;
  logic [YW-1:0] v_sync_end;
  logic          h_in_sync;
  logic          v_in_sync;
  logic          h_last;
  logic          v_last;
  logic          frame_wrap;
  logic          at_origin;

  assign cfg_in = '{
    h_total:  cfg_h_total,  h_active: cfg_h_active,
    h_front:  cfg_h_front,  h_sync:   cfg_h_sync,
    v_total:  cfg_v_total,  v_active: cfg_v_active,
    v_front:  cfg_v_front,  v_sync:   cfg_v_sync,
    hs_pol:   cfg_hs_pol,   vs_pol:   cfg_vs_pol
  };

  // Sums are widened so large porch/sync values cannot wrap past the total check.
  assign in_h_sum  = XW'(cfg_h_active) + XW'(cfg_h_front) + XW'(cfg_h_sync);
  assign in_v_sum  = YW'(cfg_v_active) + YW'(cfg_v_front) + YW'(cfg_v_sync);
  assign cfg_valid = (cfg_h_active != '0) && (cfg_v_active != '0) &&
                     (cfg_h_sync != '0) && (cfg_v_sync != '0) &&
                     (in_h_sum <= XW'(cfg_h_total)) && (in_v_sum <= YW'(cfg_v_total));

  assign h_sync_start = XW'(act.h_active) + XW'(act.h_front);
  assign h_sync_end   = h_sync_start + XW'(act.h_sync);
  assign v_sync_start = YW'(act.v_active) + YW'(act.v_front);
  assign v_sync_end   = v_sync_start + YW'(act.v_sync);
  assign h_in_sync    = (XW'(h_cnt) >= h_sync_start) && (XW'(h_cnt) < h_sync_end);
  assign v_in_sync    = (YW'(v_cnt) >= v_sync_start) && (YW'(v_cnt) < v_sync_end);
  assign h_last       = (h_cnt == act.h_total - X_BITS'(1));
  assign v_last       = (v_cnt == act.v_total - Y_BITS'(1));
  assign frame_wrap   = enable && h_last && v_last;
  assign at_origin    = (h_cnt == '0) && (v_cnt == '0);

  assign total_active_pix   = act.h_active;
  assign total_active_lines = act.v_active;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      hn_out      <= ~CFG_DEFAULT.hs_pol;
      vn_out      <= ~CFG_DEFAULT.vs_pol;
      dn_out      <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else if (!enable) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      hn_out      <= ~act.hs_pol;
      vn_out      <= ~act.vs_pol;
      dn_out      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= h_cnt;
      y           <= v_cnt;
      dn_out      <= (h_cnt < act.h_active) && (v_cnt < act.v_active);
      hn_out      <= h_in_sync ? act.hs_pol : ~act.hs_pol;
      vn_out      <= v_in_sync ? act.vs_pol : ~act.vs_pol;
      frame_start <= at_origin;
      if (at_origin) frame_count <= frame_count + 8'd1;
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + Y_BITS'(1);
      end else begin
        h_cnt <= h_cnt + X_BITS'(1);
      end
    end
  end

  // A load in the same cycle as an apply lands in pending for the next boundary.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      act         <= CFG_DEFAULT;
      pend        <= CFG_DEFAULT;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cfg_pending && (!enable || frame_wrap)) begin
        act         <= pend;
        cfg_pending <= 1'b0;
      end
      if (cfg_load) begin
        if (cfg_valid) begin
          pend        <= cfg_in;
          cfg_pending <= 1'b1;
          cfg_err     <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_gen_vg.sv
// Bench for timing_gen_vg: a cycle model pushes expected outputs into a
// scoreboard queue as stimulus is applied; entries are popped after each edge.
module tb_timing_gen_vg;
  localparam int XB = 13;
  localparam int YB = 13;

  logic          reset, clk_in, enable, cfg_load;
  logic [XB-1:0] cfg_h_total, cfg_h_active, cfg_h_front, cfg_h_sync;
  logic [YB-1:0] cfg_v_total, cfg_v_active, cfg_v_front, cfg_v_sync;
  logic          cfg_hs_pol, cfg_vs_pol;
  logic [XB-1:0] x, total_active_pix;
  logic [YB-1:0] y, total_active_lines;
  logic          hn_out, vn_out, dn_out, frame_start, cfg_pending, cfg_err;
  logic [7:0]    frame_count;

  timing_gen_vg #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .reset(reset), .clk_in(clk_in), .enable(enable), .cfg_load(cfg_load),
    .cfg_h_total(cfg_h_total), .cfg_h_active(cfg_h_active),
    .cfg_h_front(cfg_h_front), .cfg_h_sync(cfg_h_sync),
    .cfg_v_total(cfg_v_total), .cfg_v_active(cfg_v_active),
    .cfg_v_front(cfg_v_front), .cfg_v_sync(cfg_v_sync),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
    .x(x), .y(y), .hn_out(hn_out), .vn_out(vn_out), .dn_out(dn_out),
    .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
    .frame_start(frame_start), .frame_count(frame_count),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int x, y, hn, vn, dn, fs, fc, pend, err, tp, tl;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state: cfg arrays are total, active, front, sync (h then v), hs_pol, vs_pol
  int mh, mv, mfc, mpend, merr;
  int ma[10];
  int mp[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    ma = '{1650, 1280, 110, 40, 750, 720, 5, 5, 1, 1};
    mp = ma;
    mh = 0; mv = 0; mfc = 0; mpend = 0; merr = 0;
  endtask

  task automatic model_step(output exp_t e);
    int  ci[10];
    bit  wrap;
    bit  ok;
    wrap = 0;
    e = '{default: 0};
    if (enable) begin
      e.x  = mh;
      e.y  = mv;
      e.dn = (mh < ma[1] && mv < ma[5]) ? 1 : 0;
      e.hn = (mh >= ma[1] + ma[2] && mh < ma[1] + ma[2] + ma[3]) ? ma[8] : 1 - ma[8];
      e.vn = (mv >= ma[5] + ma[6] && mv < ma[5] + ma[6] + ma[7]) ? ma[9] : 1 - ma[9];
      e.fs = (mh == 0 && mv == 0) ? 1 : 0;
      if (e.fs == 1) mfc = (mfc + 1) % 256;
      wrap = (mh == ma[0] - 1) && (mv == ma[4] - 1);
      if (mh == ma[0] - 1) begin
        mh = 0;
        mv = (mv == ma[4] - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      e.hn = 1 - ma[8];
      e.vn = 1 - ma[9];
      mh = 0;
      mv = 0;
    end
    if (mpend == 1 && (!enable || wrap)) begin
      ma = mp;
      mpend = 0;
    end
    if (cfg_load) begin
      ci = '{int'(cfg_h_total), int'(cfg_h_active), int'(cfg_h_front), int'(cfg_h_sync),
             int'(cfg_v_total), int'(cfg_v_active), int'(cfg_v_front), int'(cfg_v_sync),
             int'(cfg_hs_pol), int'(cfg_vs_pol)};
      ok = ci[1] >= 1 && ci[5] >= 1 && ci[3] >= 1 && ci[7] >= 1 &&
           ci[1] + ci[2] + ci[3] <= ci[0] && ci[5] + ci[6] + ci[7] <= ci[4];
      if (ok) begin
        mp = ci; mpend = 1; merr = 0;
      end else begin
        merr = 1;
      end
    end
    e.fc = mfc; e.pend = mpend; e.err = merr; e.tp = ma[1]; e.tl = ma[5];
  endtask

  task automatic tick();
    exp_t e;
    model_step(e);
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    chk("xy", {6'd0, x, y}, {6'd0, XB'(e.x), YB'(e.y)});
    chk("sync_de", {28'd0, hn_out, vn_out, dn_out, frame_start},
        {28'd0, e.hn[0], e.vn[0], e.dn[0], e.fs[0]});
    chk("frame_count", {24'd0, frame_count}, 32'(e.fc));
    chk("cfg_state", {4'd0, cfg_pending, cfg_err, total_active_pix, total_active_lines},
        {4'd0, e.pend[0], e.err[0], XB'(e.tp), YB'(e.tl)});
  endtask

  task automatic load_cfg(input int ht, ha, hf, hs, vt, va, vf, vs, input bit hp, vp);
    cfg_h_total = XB'(ht); cfg_h_active = XB'(ha); cfg_h_front = XB'(hf); cfg_h_sync = XB'(hs);
    cfg_v_total = YB'(vt); cfg_v_active = YB'(va); cfg_v_front = YB'(vf); cfg_v_sync = YB'(vs);
    cfg_hs_pol = hp; cfg_vs_pol = vp;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic run_stats(input int n, output int dn_c, hn_c, vn_c, fs_c);
    dn_c = 0; hn_c = 0; vn_c = 0; fs_c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      dn_c += int'(dn_out); hn_c += int'(hn_out); vn_c += int'(vn_out); fs_c += int'(frame_start);
    end
  endtask

  task automatic wait_frame_top();
    int guard;
    guard = 0;
    while (!(mh == 0 && mv == 0) && guard < 500) begin
      tick();
      guard++;
    end
    chk("frame_top_timeout", 32'(guard < 500), 32'd1);
  endtask

  task automatic chk_reset_values();
    chk("rst_xy", {6'd0, x, y}, 32'd0);
    chk("rst_sync_de", {28'd0, hn_out, vn_out, dn_out, frame_start}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
    chk("rst_cfg", {4'd0, cfg_pending, cfg_err, total_active_pix, total_active_lines},
        {4'd0, 1'b0, 1'b0, XB'(1280), YB'(720)});
  endtask

  initial begin
    int dn_c, hn_c, vn_c, fs_c, guard;
    reset = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    cfg_h_total = '0; cfg_h_active = '0; cfg_h_front = '0; cfg_h_sync = '0;
    cfg_v_total = '0; cfg_v_active = '0; cfg_v_front = '0; cfg_v_sync = '0;
    cfg_hs_pol = 1'b1; cfg_vs_pol = 1'b1;
    model_reset();
    #12;
    chk_reset_values();
    #1 reset = 1'b1;

    // basic timing: applied while idle, then one full 60-cycle frame
    load_cfg(10, 4, 2, 2, 6, 3, 1, 1, 1, 1);
    tick();
    chk("idle_apply", 32'(total_active_pix), 32'd4);
    enable = 1'b1;
    run_stats(60, dn_c, hn_c, vn_c, fs_c);
    chk("basic_dn_count", 32'(dn_c), 32'd12);
    chk("basic_hs_count", 32'(hn_c), 32'd12);
    chk("basic_vs_count", 32'(vn_c), 32'd10);
    chk("basic_fs_count", 32'(fs_c), 32'd1);

    // deferred apply: load mid-frame, must not take effect until the wrap
    guard = 0;
    while (!(mh == 3 && mv == 1) && guard < 100) begin tick(); guard++; end
    load_cfg(8, 3, 1, 2, 5, 2, 1, 1, 1, 1);
    tick();
    chk("defer_pending", 32'(cfg_pending), 32'd1);
    chk("defer_old_pix", 32'(total_active_pix), 32'd4);
    wait_frame_top();
    run_stats(40, dn_c, hn_c, vn_c, fs_c);
    chk("new_dn_count", 32'(dn_c), 32'd6);
    chk("new_hs_count", 32'(hn_c), 32'd10);
    chk("new_vs_count", 32'(vn_c), 32'd8);
    chk("new_fs_count", 32'(fs_c), 32'd1);

    // invalid config is rejected, valid one clears the error
    load_cfg(5, 4, 2, 2, 6, 3, 1, 1, 1, 1);
    chk("err_set", 32'(cfg_err), 32'd1);
    chk("err_no_pending", 32'(cfg_pending), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    load_cfg(10, 4, 2, 2, 6, 3, 1, 1, 0, 0);
    chk("err_clear", 32'(cfg_err), 32'd0);

    // negative polarity, enable dropped mid-line, then restarted
    wait_frame_top();
    for (int i = 0; i < 15; i++) tick();
    enable = 1'b0;
    tick();
    chk("idle_outs", {29'd0, dn_out, hn_out, vn_out}, {29'd0, 1'b0, 1'b1, 1'b1});
    tick(); tick();
    enable = 1'b1;
    tick();
    chk("restart_origin", {6'd0, x, y}, 32'd0);
    chk("restart_fs", 32'(frame_start), 32'd1);
    for (int i = 0; i < 8; i++) tick();

    // 256 frames of a 6-cycle raster wrap frame_count back to zero
    reset = 1'b0; enable = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    load_cfg(3, 1, 0, 1, 2, 1, 0, 1, 1, 1);
    tick();
    enable = 1'b1;
    for (int i = 0; i < 256 * 6; i++) tick();
    chk("fc_wrap", {24'd0, frame_count}, 32'd0);

    // asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk_reset_values();
    #1 reset = 1'b1;
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/timing_gen_vg.md
TIMING_GEN_VG -- requirements
Module: timing_gen_vg

Interface
REQ-001 The block SHALL have parameter X_BITS, default 13, meaning horizontal counter and config width.
REQ-002 The block SHALL have parameter Y_BITS, default 13, meaning vertical counter and config width.
REQ-003 The block SHALL have these ports, one per line as name / direction / width / meaning:
- reset  input  1  asynchronous, active-low reset.
- clk_in  input  1  pixel clock; all logic on its rising edge.
- enable  input  1  run timing when high; idle when low.
- cfg_load  input  1  single-cycle pulse; captures all cfg_* inputs.
- cfg_h_total, cfg_h_active, cfg_h_front, cfg_h_sync  input  X_BITS each  line length, active pixels, front porch, sync width, in pixels.
- cfg_v_total, cfg_v_active, cfg_v_front, cfg_v_sync  input  Y_BITS each  frame length, active lines, front porch, sync width, in lines.
- cfg_hs_pol, cfg_vs_pol  input  1 each  sync active level (1 = active-high).
- x  output  X_BITS  current horizontal position.
- y  output  Y_BITS  current vertical position.
- hn_out, vn_out  output  1 each  horizontal and vertical sync.
- dn_out  output  1  data enable.
- total_active_pix  output  X_BITS  applied h_active.
- total_active_lines  output  Y_BITS  applied v_active.
- frame_start  output  1  one-cycle pulse.
- frame_count  output  8  completed frames.
- cfg_pending  output  1  a config is loaded but not yet applied.
- cfg_err  output  1  sticky error for a rejected load.

Function
REQ-004 Internal counters SHALL be h_cnt in 0..h_total-1 and v_cnt in 0..v_total-1; h_cnt increments every enabled cycle.
REQ-005 h_cnt SHALL wrap to 0 after h_total-1, and v_cnt SHALL increment at the same edge; v_cnt SHALL wrap to 0 after v_total-1.
REQ-006 All outputs SHALL be registered and decoded from counter values, so outputs lag the counters by exactly 1 cycle.
REQ-007 Output timing SHALL be:
- x = h_cnt and y = v_cnt.
- dn_out = 1 only when h_cnt < h_active and v_cnt < v_active.
REQ-008 hn_out SHALL equal hs_pol when h_active+h_front <= h_cnt < h_active+h_front+h_sync, and ~hs_pol otherwise.
REQ-009 vn_out SHALL equal vs_pol when v_active+v_front <= v_cnt < v_active+v_front+v_sync, and ~vs_pol otherwise; vn_out transitions only alongside h_cnt = 0.
REQ-010 frame_start SHALL pulse for 1 cycle coincident with output x=0, y=0.
REQ-011 frame_count SHALL increment on each frame_start and wrap 255 -> 0.
REQ-012 A cfg_load pulse with a valid config SHALL capture the config into pending registers and set cfg_pending.
REQ-013 The pending config SHALL be applied when both counters wrap to (0,0), and cfg_pending SHALL clear on the same edge; active config SHALL never change mid-frame.
REQ-014 A config SHALL be valid only when all of the following hold:
- h_active >= 1 and v_active >= 1.
- h_sync >= 1 and v_sync >= 1.
- h_active+h_front+h_sync <= h_total.
- v_active+v_front+v_sync <= v_total.
REQ-015 A load with an invalid config SHALL be ignored, leaving the pending and active configs unchanged, and SHALL set cfg_err.
REQ-016 cfg_err SHALL clear only on the next valid cfg_load.
REQ-017 A second valid cfg_load before application SHALL overwrite the pending config (last load wins).
REQ-018 While enable=0:
- counters are held at 0.
- dn_out=0, hn_out=~hs_pol, vn_out=~vs_pol, frame_start=0.
- if cfg_pending is set, the pending config is applied immediately.
REQ-019 On enable rising, the counters SHALL start from (0,0), and the first frame_start SHALL appear 1 cycle later.
REQ-020 total_active_pix and total_active_lines SHALL always reflect the active config, never the pending one.

Reset
REQ-021 On reset low, the block SHALL asynchronously clear the counters, frame_count, cfg_pending, cfg_err, x, y, dn_out and frame_start.
REQ-022 On reset low, the active config SHALL load defaults 1650/1280/110/40 (horizontal), 750/720/5/5 (vertical), hs_pol=vs_pol=1, and hn_out=vn_out=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no partial frame_count increment.

Verification
REQ-024 Basic timing: load h 10/4/2/2, v 6/3/1/1, pol 1, then enable -> dn_out high 4 cycles per line on lines 0-2; hn_out high at x=6,7; vn_out high for all of line 4; frame_start every 60 cycles.
REQ-025 Deferred apply: cfg_load at x=3, y=1 -> cfg_pending=1 until the frame wrap; the new timing is used from the next frame_start only.
REQ-026 Invalid config: load h_total=5 with active 4, front 2, sync 2 -> cfg_err=1 and timing unchanged; then a valid load -> cfg_err=0.
REQ-027 Polarity and enable: pol=0, enable dropped mid-line -> next cycle dn_out=0, hn_out=1, vn_out=1; re-enable -> x=0, y=0 and frame_start 1 cycle later.
REQ-028 Wrap: run 256 frames -> frame_count reads 0; asynchronous reset mid-frame -> all outputs at reset values immediately.
